// File: rtl/load_align_unit.sv
// Multi-cycle load unit. It issues one or two word-aligned memory reads per load,
// then extracts the addressed bytes and sign- or zero-extends them into the result.
module load_align_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TAG_W       = 5,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_fault
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [OB-1:0]     off_q, off_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_fault_q, rsp_fault_d;

  function automatic logic [3:0] size_of(input logic [2:0] t);
    case (t)
      3'b000, 3'b011: size_of = 4'd1;
      3'b001, 3'b100: size_of = 4'd2;
      3'b010, 3'b101: size_of = 4'd4;
      default:        size_of = 4'd8;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] t);
    is_illegal = (t == 3'b111) || ((XLEN == 32) && ((t == 3'b101) || (t == 3'b110)));
  endfunction

  // Size is a power of two, so "addr mod size" is the low address bits under a mask.
  function automatic logic is_misaligned(input logic [2:0] a_lo, input logic [2:0] t);
    logic [3:0] sz;
    logic [2:0] mask;
    sz   = size_of(t);
    mask = sz[2:0] - 3'd1;
    is_misaligned = |(a_lo & mask);
  endfunction

  function automatic logic spans_two(input logic [OB-1:0] off, input logic [2:0] t);
    logic [4:0] last;
    last = 5'(off) + 5'(size_of(t));
    spans_two = last > 5'(NB);
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] lo,
                                              input logic [XLEN-1:0] hi,
                                              input logic [OB-1:0]   off,
                                              input logic [2:0]      t);
    logic [2*XLEN-1:0] win;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    win = {hi, lo} >> {off, 3'b000};
    b_s = win[7:0];
    h_s = win[15:0];
    w_s = win[31:0];
    case (t)
      3'b000:  extract = XLEN'(b_s);
      3'b001:  extract = XLEN'(h_s);
      3'b010:  extract = XLEN'(w_s);
      3'b011:  extract = XLEN'(win[7:0]);
      3'b100:  extract = XLEN'(win[15:0]);
      3'b101:  extract = XLEN'(win[31:0]);
      default: extract = win[XLEN-1:0];
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    off_d           = off_q;
    tag_d           = tag_q;
    rdata0_d        = rdata0_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_tag_d       = rsp_tag_q;
    rsp_fault_d     = rsp_fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          type_d   = req_type;
          off_d    = req_addr[OB-1:0];
          tag_d    = req_tag;
          rdata0_d = '0;
          if (is_illegal(req_type) ||
              (!MISALIGN_EN && is_misaligned(req_addr[2:0], req_type))) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_tag_d   = req_tag;
            rsp_fault_d = 1'b1;
          end else begin
            state_d         = REQ0;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
          end
        end
      end
      REQ0, REQ1: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = (state_q == REQ0) ? WAIT0 : WAIT1;
        end
      end
      WAIT0: begin
        if (mem_rsp_valid) begin
          rdata0_d = mem_rdata;
          if (spans_two(off_q, type_q)) begin
            state_d         = REQ1;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = mem_addr_q + ADDR_W'(NB);
          end else begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = extract(mem_rdata, '0, off_q, type_q);
            rsp_tag_d   = tag_q;
            rsp_fault_d = 1'b0;
          end
        end
      end
      WAIT1: begin
        if (mem_rsp_valid) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = extract(rdata0_q, mem_rdata, off_q, type_q);
          rsp_tag_d   = tag_q;
          rsp_fault_d = 1'b0;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      type_q          <= '0;
      off_q           <= '0;
      tag_q           <= '0;
      rdata0_q        <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_tag_q       <= '0;
      rsp_fault_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      type_q          <= type_d;
      off_q           <= off_d;
      tag_q           <= tag_d;
      rdata0_q        <= rdata0_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_tag_q       <= rsp_tag_d;
      rsp_fault_q     <= rsp_fault_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_fault     = rsp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three instances (XLEN=32 misaligned-on, XLEN=32 misaligned-off,
// XLEN=64), a word memory responder per instance, and a byte-level reference model.
module tb_load_align_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  logic        req_valid[3];
  logic [2:0]  req_type[3];
  logic [31:0] req_addr[3];
  logic [4:0]  req_tag[3];
  logic        req_ready[3];
  logic        mem_req_valid[3];
  logic        mem_req_ready[3];
  logic [31:0] mem_addr[3];
  logic        mem_rsp_valid[3];
  logic [63:0] mem_rdata[3];
  logic        rsp_valid[3];
  logic        rsp_ready[3];
  logic [63:0] rsp_data[3];
  logic [4:0]  rsp_tag[3];
  logic        rsp_fault[3];
  logic [31:0] rd32_0, rd32_1;
  logic [63:0] rd64_2;

  assign rsp_data[0] = {32'h0, rd32_0};
  assign rsp_data[1] = {32'h0, rd32_1};
  assign rsp_data[2] = rd64_2;

  load_align_unit #(.XLEN(32), .ADDR_W(32), .TAG_W(5), .MISALIGN_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_type(req_type[0]), .req_addr(req_addr[0]), .req_tag(req_tag[0]),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready[0]), .mem_addr(mem_addr[0]),
    .mem_rsp_valid(mem_rsp_valid[0]), .mem_rdata(mem_rdata[0][31:0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rd32_0),
    .rsp_tag(rsp_tag[0]), .rsp_fault(rsp_fault[0]));

  load_align_unit #(.XLEN(32), .ADDR_W(32), .TAG_W(5), .MISALIGN_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_type(req_type[1]), .req_addr(req_addr[1]), .req_tag(req_tag[1]),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready[1]), .mem_addr(mem_addr[1]),
    .mem_rsp_valid(mem_rsp_valid[1]), .mem_rdata(mem_rdata[1][31:0]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rd32_1),
    .rsp_tag(rsp_tag[1]), .rsp_fault(rsp_fault[1]));

  load_align_unit #(.XLEN(64), .ADDR_W(32), .TAG_W(5), .MISALIGN_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_type(req_type[2]), .req_addr(req_addr[2]), .req_tag(req_tag[2]),
    .mem_req_valid(mem_req_valid[2]), .mem_req_ready(mem_req_ready[2]), .mem_addr(mem_addr[2]),
    .mem_rsp_valid(mem_rsp_valid[2]), .mem_rdata(mem_rdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rd64_2),
    .rsp_tag(rsp_tag[2]), .rsp_fault(rsp_fault[2]));

  typedef struct {
    int          d;
    logic [63:0] data;
    logic        fault;
    logic [4:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] maddr_log[$];
  logic [63:0] mem [logic [33:0]];
  int          stall[3];
  int          rsp_lat[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mem_wr(input int d, input logic [31:0] a, input logic [63:0] v);
    mem[{2'(d), a}] = v;
  endtask

  function automatic logic [63:0] mem_rd(input int d, input logic [31:0] a);
    logic [33:0] k;
    k = {2'(d), a};
    return mem.exists(k) ? mem[k] : 64'h0;
  endfunction

  // Reference: gather the load's bytes one at a time from little-endian memory words.
  task automatic model(input int d, input logic [2:0] t, input logic [31:0] a,
                       output logic [63:0] data, output logic fault);
    int xl, nb, sz;
    bit sgn, misen, ill;
    logic [31:0] ba;
    logic [63:0] w, v;
    xl = (d == 2) ? 64 : 32;
    nb = xl / 8;
    misen = (d != 1);
    sz = 1; sgn = 0;
    case (t)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: begin sz = 4; sgn = (xl == 64); end
      3'd3: begin sz = 1; sgn = 0; end
      3'd4: begin sz = 2; sgn = 0; end
      3'd5: begin sz = 4; sgn = 0; end
      3'd6: begin sz = 8; sgn = 0; end
      default: begin sz = 1; sgn = 0; end
    endcase
    ill = (t == 3'd7) || (xl == 32 && (t == 3'd5 || t == 3'd6));
    fault = ill || (!misen && (a % sz) != 0);
    data = 64'h0;
    if (!fault) begin
      v = 64'h0;
      for (int i = 0; i < sz; i++) begin
        ba = a + i;
        w = mem_rd(d, ba & ~(nb - 1));
        v = v | (((w >> (8 * (ba % nb))) & 64'hFF) << (8 * i));
      end
      if (sgn && v[8*sz-1]) v = v | (~64'h0 << (8 * sz));
      if (xl == 32) v = v & 64'hFFFF_FFFF;
      data = v;
    end
  endtask

  // Memory responders: accept after the configured stall, answer rsp_lat negedges later.
  for (genvar g = 0; g < 3; g++) begin : g_mem
    initial begin
      int pend;
      bit in_stall;
      logic [31:0] pa, hold;
      pend = 0; in_stall = 0; pa = '0; hold = '0;
      mem_req_ready[g] = 1'b0;
      mem_rsp_valid[g] = 1'b0;
      mem_rdata[g]     = 64'hDEAD_BEEF_DEAD_BEEF;
      forever begin
        @(negedge clk);
        mem_rsp_valid[g] = 1'b0;
        mem_rdata[g]     = 64'hDEAD_BEEF_DEAD_BEEF;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mem_rsp_valid[g] = 1'b1;
            mem_rdata[g]     = mem_rd(g, pa);
          end
        end
        mem_req_ready[g] = 1'b0;
        if (rst_n && mem_req_valid[g]) begin
          if (in_stall) chk("mem_addr_stable", 64'(mem_addr[g]), 64'(hold));
          if (stall[g] > 0) begin
            stall[g]--;
            in_stall = 1;
            hold = mem_addr[g];
          end else begin
            in_stall = 0;
            mem_req_ready[g] = 1'b1;
            pa = mem_addr[g];
            maddr_log.push_back(pa);
            pend = rsp_lat[g];
          end
        end else begin
          in_stall = 0;
        end
      end
    end
  end

  // Every cycle a response is presented, it must match the model's expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 3; d++) begin
          if (rsp_valid[d]) begin
            if (exp_q.size() == 0 || exp_q[0].d != d) begin
              chk("unexpected_rsp_valid", 64'(d), 64'hFF);
            end else begin
              chk("cmp_data", rsp_data[d], exp_q[0].data);
              chk("cmp_fault", 64'(rsp_fault[d]), 64'(exp_q[0].fault));
              chk("cmp_tag", 64'(rsp_tag[d]), 64'(exp_q[0].tag));
              chk("cmp_req_ready_busy", 64'(req_ready[d]), 64'h0);
              if (rsp_ready[d]) void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic do_load(input string name, input int d, input logic [2:0] t,
                         input logic [31:0] a, input logic [4:0] tag,
                         input int mstall, input int rstall,
                         input logic [63:0] exp_data, input logic exp_fault,
                         input int exp_beats, input logic [31:0] exp_a0);
    logic [63:0] md;
    logic mf;
    exp_t e;
    int n, nb;
    nb = (d == 2) ? 8 : 4;
    model(d, t, a, md, mf);
    chk({name, "_model_data"}, md, exp_data);
    chk({name, "_model_fault"}, 64'(mf), 64'(exp_fault));
    e.d = d; e.data = md; e.fault = mf; e.tag = tag;
    exp_q.push_back(e);
    maddr_log.delete();
    stall[d] = mstall;
    chk({name, "_req_ready_idle"}, 64'(req_ready[d]), 64'h1);
    req_valid[d] = 1'b1; req_type[d] = t; req_addr[d] = a; req_tag[d] = tag;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_addr[d] = 32'h0BAD_0000; req_tag[d] = ~tag;
    chk({name, "_req_ready_after_accept"}, 64'(req_ready[d]), 64'h0);
    n = 0;
    while (!rsp_valid[d] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid[d]) begin
      chk({name, "_rsp_timeout"}, 64'(n), 64'h0);
      exp_q.delete();
      return;
    end
    chk({name, "_latency"}, 64'(n), 64'(mf ? 0 : 3 * exp_beats + mstall));
    for (int i = 0; i < rstall; i++) begin
      @(posedge clk); #1;
      chk({name, "_rsp_valid_held"}, 64'(rsp_valid[d]), 64'h1);
    end
    rsp_ready[d] = 1'b1;
    chk({name, "_data"}, rsp_data[d], exp_data);
    chk({name, "_fault"}, 64'(rsp_fault[d]), 64'(exp_fault));
    chk({name, "_tag"}, 64'(rsp_tag[d]), 64'(tag));
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk({name, "_rsp_valid_drop"}, 64'(rsp_valid[d]), 64'h0);
    chk({name, "_req_ready_back"}, 64'(req_ready[d]), 64'h1);
    chk({name, "_beats"}, 64'(maddr_log.size()), 64'(exp_beats));
    if (maddr_log.size() >= 1) chk({name, "_addr0"}, 64'(maddr_log[0]), 64'(exp_a0));
    if (maddr_log.size() >= 2) chk({name, "_addr1"}, 64'(maddr_log[1]), 64'(32'(exp_a0 + nb)));
    chk({name, "_scoreboard_empty"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic chk_reset_state(input string name, input int d);
    chk({name, "_req_ready"}, 64'(req_ready[d]), 64'h1);
    chk({name, "_mem_req_valid"}, 64'(mem_req_valid[d]), 64'h0);
    chk({name, "_mem_addr"}, 64'(mem_addr[d]), 64'h0);
    chk({name, "_rsp_valid"}, 64'(rsp_valid[d]), 64'h0);
    chk({name, "_rsp_data"}, rsp_data[d], 64'h0);
    chk({name, "_rsp_tag"}, 64'(rsp_tag[d]), 64'h0);
    chk({name, "_rsp_fault"}, 64'(rsp_fault[d]), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_type[d] = 3'd0; req_addr[d] = 32'h0; req_tag[d] = 5'd0;
      rsp_ready[d] = 1'b0; stall[d] = 0; rsp_lat[d] = 2;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    for (int d = 0; d < 3; d++) chk_reset_state("reset", d);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // XLEN=32, misaligned loads serviced
    mem_wr(0, 32'h100, 64'h8899_AABB);
    do_load("lw_aligned", 0, 3'd2, 32'h100, 5'd3, 0, 0, 64'h8899_AABB, 1'b0, 1, 32'h100);
    mem_wr(0, 32'h100, 64'h8012_3456);
    do_load("lb_sext", 0, 3'd0, 32'h103, 5'd7, 0, 0, 64'hFFFF_FF80, 1'b0, 1, 32'h100);
    do_load("lbu", 0, 3'd3, 32'h103, 5'd8, 0, 0, 64'h0000_0080, 1'b0, 1, 32'h100);
    do_load("lhu", 0, 3'd4, 32'h102, 5'd9, 0, 0, 64'h0000_8012, 1'b0, 1, 32'h100);
    do_load("lh_pos", 0, 3'd1, 32'h100, 5'd10, 0, 0, 64'h0000_3456, 1'b0, 1, 32'h100);
    mem_wr(0, 32'h200, 64'hAB00_0000);
    mem_wr(0, 32'h204, 64'h0000_00CD);
    do_load("lh_span", 0, 3'd1, 32'h203, 5'd11, 0, 0, 64'hFFFF_CDAB, 1'b0, 2, 32'h200);
    do_load("lhu_span", 0, 3'd4, 32'h203, 5'd12, 0, 1, 64'h0000_CDAB, 1'b0, 2, 32'h200);
    mem_wr(0, 32'hFFFF_FFFC, 64'hBEEF_1234);
    mem_wr(0, 32'h0, 64'h5566_7788);
    do_load("lw_wrap", 0, 3'd2, 32'hFFFF_FFFE, 5'd13, 0, 0, 64'h7788_BEEF, 1'b0, 2, 32'hFFFF_FFFC);
    do_load("backpressure", 0, 3'd2, 32'h100, 5'd14, 3, 2, 64'h8012_3456, 1'b0, 1, 32'h100);
    do_load("illegal_111", 0, 3'd7, 32'h100, 5'd15, 0, 1, 64'h0, 1'b1, 0, 32'h0);

    // XLEN=32, misaligned loads fault
    mem_wr(1, 32'h100, 64'h8012_3456);
    do_load("mis_lw_fault", 1, 3'd2, 32'h102, 5'd16, 0, 0, 64'h0, 1'b1, 0, 32'h0);
    do_load("ld_at_32_fault", 1, 3'd6, 32'h100, 5'd17, 0, 0, 64'h0, 1'b1, 0, 32'h0);
    do_load("lwu_at_32_fault", 1, 3'd5, 32'h100, 5'd18, 0, 0, 64'h0, 1'b1, 0, 32'h0);
    do_load("lh_aligned_nomis", 1, 3'd1, 32'h102, 5'd19, 0, 0, 64'hFFFF_8012, 1'b0, 1, 32'h100);

    // XLEN=64
    mem_wr(2, 32'h1000, 64'h0123_4567_89AB_CDEF);
    mem_wr(2, 32'h1008, 64'h1122_3344_5566_7788);
    do_load("ld", 2, 3'd6, 32'h1000, 5'd20, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1, 32'h1000);
    do_load("lw64_hi", 2, 3'd2, 32'h1004, 5'd21, 0, 0, 64'h0000_0000_0123_4567, 1'b0, 1, 32'h1000);
    do_load("lw64_sext", 2, 3'd2, 32'h1000, 5'd22, 0, 0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1, 32'h1000);
    do_load("lwu64", 2, 3'd5, 32'h1000, 5'd23, 0, 0, 64'h0000_0000_89AB_CDEF, 1'b0, 1, 32'h1000);
    do_load("ld_span", 2, 3'd6, 32'h1004, 5'd24, 1, 1, 64'h5566_7788_0123_4567, 1'b0, 2, 32'h1000);

    // Reset pulsed while the second beat is outstanding; its late response must be ignored
    mem_wr(2, 32'h2000, 64'hFFFF_FFFF_FFFF_FFFF);
    mem_wr(2, 32'h2008, 64'hFFFF_FFFF_FFFF_FFFF);
    maddr_log.delete();
    rsp_lat[2] = 6;
    req_valid[2] = 1'b1; req_type[2] = 3'd2; req_addr[2] = 32'h2006; req_tag[2] = 5'd25;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    n = 0;
    while (maddr_log.size() < 2 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reached_wait1", 64'(maddr_log.size()), 64'h2);
    rst_n = 1'b0;
    #2;
    chk_reset_state("midop_reset", 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("stale_rsp_valid", 64'(rsp_valid[2]), 64'h0);
      chk("stale_mem_req_valid", 64'(mem_req_valid[2]), 64'h0);
      chk("stale_req_ready", 64'(req_ready[2]), 64'h1);
    end
    rsp_lat[2] = 2;
    do_load("ld_after_reset", 2, 3'd6, 32'h1000, 5'd26, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1, 32'h1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
